// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data-memory arbiter with port-1 lock and one-cycle read return
module dmem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_size,
  input  logic        i_p0_write,
  output logic        o_p0_gnt,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_req,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_size,
  input  logic        i_p1_write,
  output logic        o_p1_gnt,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  input  logic        i_p1_lock,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_size,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t state, state_next;
  logic last, rv_pend, rv_port, locked, g0, g1, wr;
  logic [31:0] addr;
  logic unused_addr_bits;
  // grant decision (last=1 means port 1 won most recently, so port 0 takes the next tie) and ownership tracking
  always_comb begin
    locked = (state == LOCK) & i_p1_lock;
    g1 = i_rst_n & i_p1_req & (locked | ~i_p0_req | ~last);
    g0 = i_rst_n & i_p0_req & ~locked & ~g1;
    wr = g1 ? i_p1_write : i_p0_write;
    addr = g1 ? i_p1_addr : i_p0_addr;
    state_next = (i_p1_lock & ((state == LOCK) | g1)) ? LOCK : ARB;
  end
  // memory-side request mux and read-return steering
  always_comb begin
    o_p0_gnt = g0;
    o_p1_gnt = g1;
    o_mem_addr = {{(32-MEM_ADDR_WIDTH){1'b0}}, addr[MEM_ADDR_WIDTH-1:2], 2'b00};
    o_mem_wdata = g1 ? i_p1_wdata : i_p0_wdata;
    o_mem_size = wr ? (g1 ? i_p1_size : i_p0_size) : 4'hF;
    o_mem_write = (g0 | g1) & wr;
    o_mem_read = (g0 | g1) & ~wr;
    o_p0_rvalid = i_rst_n & rv_pend & ~rv_port;
    o_p1_rvalid = i_rst_n & rv_pend & rv_port;
    o_p0_rdata = o_p0_rvalid ? i_mem_rdata : '0;
    o_p1_rdata = o_p1_rvalid ? i_mem_rdata : '0;
    o_busy = i_rst_n & ((state == LOCK) | rv_pend);
  end
  assign unused_addr_bits = ^{addr[31:MEM_ADDR_WIDTH], addr[1:0]};
  // state, round-robin pointer and one-deep read-return pipeline
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ARB;
      last <= 1'b1;
      rv_pend <= 1'b0;
      rv_port <= 1'b0;
    end else begin
      state <= state_next;
      if (g0 | g1) last <= g1;
      rv_pend <= (g0 | g1) & ~wr;
      rv_port <= g1;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors plus a per-cycle behavioural model for dmem_arbiter
module tb_dmem_arbiter;
  logic i_clk = 1'b0;
  logic i_rst_n, i_p1_lock;
  logic i_p0_req, i_p0_write, i_p1_req, i_p1_write;
  logic [31:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata, i_mem_rdata;
  logic [3:0] i_p0_size, i_p1_size;
  logic o_p0_gnt, o_p0_rvalid, o_p1_gnt, o_p1_rvalid, o_mem_write, o_mem_read, o_busy;
  logic [31:0] o_p0_rdata, o_p1_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0] o_mem_size;
  int checks = 0, errors = 0;
  int prefer = 0;
  int pend = -1;
  bit owned = 1'b0;

  dmem_arbiter #(.MEM_ADDR_WIDTH(12)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_p0_req(i_p0_req), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata), .i_p0_size(i_p0_size), .i_p0_write(i_p0_write),
    .o_p0_gnt(o_p0_gnt), .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata),
    .i_p1_req(i_p1_req), .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata), .i_p1_size(i_p1_size), .i_p1_write(i_p1_write),
    .o_p1_gnt(o_p1_gnt), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata),
    .i_p1_lock(i_p1_lock),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
    .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who wins this cycle, what the memory sees, and what returns next cycle.
  always @(negedge i_clk) begin : model
    int win;
    logic wr;
    logic [31:0] a, wd;
    logic [3:0] sz;
    win = -1;
    if (i_rst_n) begin
      if (owned && i_p1_lock) win = i_p1_req ? 1 : -1;
      else if (i_p0_req && i_p1_req) win = prefer;
      else if (i_p0_req) win = 0;
      else if (i_p1_req) win = 1;
    end
    wr = (win == 1) ? i_p1_write : i_p0_write;
    a = (win == 1) ? i_p1_addr : i_p0_addr;
    wd = (win == 1) ? i_p1_wdata : i_p0_wdata;
    sz = (win == 1) ? i_p1_size : i_p0_size;
    chk("m_gnt0", 32'(o_p0_gnt), 32'(win == 0));
    chk("m_gnt1", 32'(o_p1_gnt), 32'(win == 1));
    chk("m_rd", 32'(o_mem_read), 32'(win >= 0 && !wr));
    chk("m_wr", 32'(o_mem_write), 32'(win >= 0 && wr));
    chk("m_rv0", 32'(o_p0_rvalid), 32'(i_rst_n && pend == 0));
    chk("m_rv1", 32'(o_p1_rvalid), 32'(i_rst_n && pend == 1));
    chk("m_rdata0", o_p0_rdata, (i_rst_n && pend == 0) ? i_mem_rdata : 32'h0);
    chk("m_rdata1", o_p1_rdata, (i_rst_n && pend == 1) ? i_mem_rdata : 32'h0);
    chk("m_busy", 32'(o_busy), 32'(i_rst_n && (owned || pend >= 0)));
    if (win >= 0) begin
      chk("m_addr", o_mem_addr, a & 32'h0000_0FFC);
      chk("m_wdata", o_mem_wdata, wd);
      chk("m_size", 32'(o_mem_size), 32'(wr ? sz : 4'hF));
    end
    if (!i_rst_n) begin
      prefer = 0;
      owned = 1'b0;
      pend = -1;
    end else begin
      if (win >= 0) prefer = 1 - win;
      owned = i_p1_lock && (owned || win == 1);
      pend = (win >= 0 && !wr) ? win : -1;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_mem_rdata = $urandom;
  endtask

  task automatic idle();
    i_p0_req = 1'b0; i_p0_write = 1'b0;
    i_p1_req = 1'b0; i_p1_write = 1'b0;
    i_p1_lock = 1'b0;
  endtask

  task automatic drv0(input logic req, input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] sz);
    i_p0_req = req; i_p0_addr = a; i_p0_write = w; i_p0_wdata = wd; i_p0_size = sz;
  endtask

  task automatic drv1(input logic req, input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] sz);
    i_p1_req = req; i_p1_addr = a; i_p1_write = w; i_p1_wdata = wd; i_p1_size = sz;
  endtask

  initial begin
    int n0, n1;
    idle();
    i_rst_n = 1'b0;
    drv0(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drv1(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    i_mem_rdata = 32'h0;
    repeat (2) tick();
    #2 chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_gnt0", 32'(o_p0_gnt), 32'h0);
    // two reads from reset: port 0 wins the first tie
    tick();
    i_rst_n = 1'b1;
    drv0(1'b1, 32'h010, 1'b0, 32'h0, 4'hF);
    drv1(1'b1, 32'h020, 1'b0, 32'h0, 4'hF);
    #2 chk("c0_gnt0", 32'(o_p0_gnt), 32'h1);
    chk("c0_gnt1", 32'(o_p1_gnt), 32'h0);
    chk("c0_addr", o_mem_addr, 32'h010);
    chk("c0_rd", 32'(o_mem_read), 32'h1);
    tick();
    i_p0_req = 1'b0;
    i_mem_rdata = 32'hCAFE0001;
    #2 chk("c1_gnt1", 32'(o_p1_gnt), 32'h1);
    chk("c1_addr", o_mem_addr, 32'h020);
    chk("c1_rv0", 32'(o_p0_rvalid), 32'h1);
    chk("c1_rdata0", o_p0_rdata, 32'hCAFE0001);
    chk("c1_rv1", 32'(o_p1_rvalid), 32'h0);
    tick();
    idle();
    i_mem_rdata = 32'hBEEF0002;
    #2 chk("c2_rv1", 32'(o_p1_rvalid), 32'h1);
    chk("c2_rdata1", o_p1_rdata, 32'hBEEF0002);
    chk("c2_rdata0", o_p0_rdata, 32'h0);
    // byte write: word-aligned address, strobes passed through, no read return
    tick();
    drv0(1'b1, 32'h1007, 1'b1, 32'hAABBCCDD, 4'b0010);
    #2 chk("w_wr", 32'(o_mem_write), 32'h1);
    chk("w_rd", 32'(o_mem_read), 32'h0);
    chk("w_addr", o_mem_addr, 32'h004);
    chk("w_size", 32'(o_mem_size), 32'h2);
    chk("w_wdata", o_mem_wdata, 32'hAABBCCDD);
    tick();
    idle();
    #2 chk("w_norv", 32'(o_p0_rvalid), 32'h0);
    chk("w_busy", 32'(o_busy), 32'h0);
    // port 1 takes the lock; port 0 is held off for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      drv0(1'b1, 32'h100, 1'b0, 32'h0, 4'hF);
      drv1(1'b1, 32'h200, 1'b0, 32'h0, 4'hF);
      i_p1_lock = 1'b1;
      #2 chk("lk_gnt0", 32'(o_p0_gnt), 32'h0);
      chk("lk_gnt1", 32'(o_p1_gnt), 32'h1);
      if (i > 0) chk("lk_busy", 32'(o_busy), 32'h1);
    end
    tick();
    i_p1_lock = 1'b0;
    #2 chk("ul_gnt0", 32'(o_p0_gnt), 32'h1);
    chk("ul_gnt1", 32'(o_p1_gnt), 32'h0);
    // continuous contention alternates, starting with port 1
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #2 n0 += int'(o_p0_gnt);
      n1 += int'(o_p1_gnt);
      chk("rr_alt", 32'(o_p1_gnt), 32'(i % 2 == 0));
    end
    chk("rr_n0", 32'(n0), 32'd5);
    chk("rr_n1", 32'(n1), 32'd5);
    // lock is ignored when port 0 wins
    tick();
    idle();
    drv1(1'b1, 32'h300, 1'b1, 32'h12345678, 4'hF);
    #2 chk("pre_gnt1", 32'(o_p1_gnt), 32'h1);
    tick();
    drv0(1'b1, 32'h040, 1'b1, 32'h55, 4'h1);
    i_p1_lock = 1'b1;
    #2 chk("ig_gnt0", 32'(o_p0_gnt), 32'h1);
    chk("ig_gnt1", 32'(o_p1_gnt), 32'h0);
    tick();
    idle();
    i_p1_lock = 1'b1;
    #2 chk("ig_busy", 32'(o_busy), 32'h0);
    tick();
    idle();
    // reset right after a port 0 read grant squashes the return and restores port 0 priority
    tick();
    drv0(1'b1, 32'h080, 1'b0, 32'h0, 4'hF);
    #2 chk("rr0_gnt0", 32'(o_p0_gnt), 32'h1);
    tick();
    i_rst_n = 1'b0;
    i_mem_rdata = 32'h5A5A5A5A;
    #2 chk("rs_rv0", 32'(o_p0_rvalid), 32'h0);
    chk("rs_gnt0", 32'(o_p0_gnt), 32'h0);
    chk("rs_rd", 32'(o_mem_read), 32'h0);
    tick();
    i_rst_n = 1'b1;
    drv1(1'b1, 32'h0C0, 1'b0, 32'h0, 4'hF);
    #2 chk("ar_gnt0", 32'(o_p0_gnt), 32'h1);
    chk("ar_gnt1", 32'(o_p1_gnt), 32'h0);
    chk("ar_busy", 32'(o_busy), 32'h0);
    chk("ar_rv0", 32'(o_p0_rvalid), 32'h0);
    // mixed traffic checked by the model only
    for (int i = 0; i < 80; i++) begin
      tick();
      drv0(1'($urandom), $urandom, 1'($urandom), $urandom, 4'($urandom));
      drv1(1'($urandom), $urandom, 1'($urandom), $urandom, 4'($urandom));
      i_p1_lock = ($urandom_range(0, 2) == 0);
    end
    tick();
    idle();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
